// File: rtl/fib_pkg.sv
// Package: fib_pkg
// Shared definitions for the Fibonacci calculator control path:
//   - ALU opcodes understood by the datapath
//   - register-file indices (R0 count, R1 a, R2 b, R3 temp)
//   - 4-bit controller state encoding
//   - the control word the decoder produces for each state
package fib_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;  // A + B
   localparam logic [2:0] OP_SUB  = 3'b001;  // A - B
   localparam logic [2:0] OP_DEC  = 3'b010;  // A - 1
   localparam logic [2:0] OP_PASS = 3'b011;  // A

   localparam logic [1:0] REG_CNT = 2'd0;
   localparam logic [1:0] REG_A   = 2'd1;
   localparam logic [1:0] REG_B   = 2'd2;
   localparam logic [1:0] REG_T   = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LD_N = 4'd1,
      S_LD_A = 4'd2,
      S_LD_B = 4'd3,
      S_TEST = 4'd4,
      S_ADD  = 4'd5,
      S_MOV1 = 4'd6,
      S_MOV2 = 4'd7,
      S_DEC  = 4'd8,
      S_DONE = 4'd9
   } state_e;

   // Everything the datapath needs from one state, except the SIZE-wide load value.
   typedef struct packed {
      logic [1:0] wrt_addr;
      logic [1:0] rd_addr1;
      logic [1:0] rd_addr2;
      logic       wrt_en;
      logic       load_data;
      logic [2:0] alu_opcode;
      logic       busy;
      logic       done;
   } ctrl_word_t;

endpackage

// File: rtl/fib_ctrl_decode.sv
// Module: fib_ctrl_decode
// Purely combinational state -> control word decode for fib_controller.
// Ports:
//   state  in   state_e       current controller state
//   n_q    in   SIZE          captured index n (loaded into R0 in LD_N)
//   ctrl   out  ctrl_word_t   addresses, write enable, load select, opcode, busy, done
//   count  out  SIZE          immediate load value
module fib_ctrl_decode
   import fib_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  state_e          state,
   input  logic [SIZE-1:0] n_q,
   output ctrl_word_t      ctrl,
   output logic [SIZE-1:0] count
);

   always_comb begin
      ctrl            = '0;
      ctrl.alu_opcode = OP_PASS;
      ctrl.busy       = (state != S_IDLE);
      count           = '0;
      case (state)
         S_LD_N: begin
            ctrl.wrt_en    = 1'b1;
            ctrl.load_data = 1'b1;
            ctrl.wrt_addr  = REG_CNT;
            count          = n_q;
         end
         S_LD_A: begin
            ctrl.wrt_en    = 1'b1;
            ctrl.load_data = 1'b1;
            ctrl.wrt_addr  = REG_A;
            count          = '0;
         end
         S_LD_B: begin
            ctrl.wrt_en    = 1'b1;
            ctrl.load_data = 1'b1;
            ctrl.wrt_addr  = REG_B;
            count          = SIZE'(1);
         end
         S_TEST: begin
            // R0 passes through the ALU so the datapath reports zero_flag for it.
            ctrl.rd_addr1 = REG_CNT;
         end
         S_ADD: begin
            ctrl.rd_addr1   = REG_A;
            ctrl.rd_addr2   = REG_B;
            ctrl.alu_opcode = OP_ADD;
            ctrl.wrt_addr   = REG_T;
            ctrl.wrt_en     = 1'b1;
         end
         S_MOV1: begin
            ctrl.rd_addr1 = REG_B;
            ctrl.wrt_addr = REG_A;
            ctrl.wrt_en   = 1'b1;
         end
         S_MOV2: begin
            ctrl.rd_addr1 = REG_T;
            ctrl.wrt_addr = REG_B;
            ctrl.wrt_en   = 1'b1;
         end
         S_DEC: begin
            ctrl.rd_addr1   = REG_CNT;
            ctrl.alu_opcode = OP_DEC;
            ctrl.wrt_addr   = REG_CNT;
            ctrl.wrt_en     = 1'b1;
         end
         S_DONE: begin
            ctrl.done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fib_controller.sv
// Module: fib_controller
// Control-path FSM for the Fibonacci calculator. Sequences a 4-register / ALU
// datapath to compute F(n) (F(0)=0, F(1)=1); the result sits in R1 when done pulses.
// Build option: FIB_CTRL_ABORT_EN adds an abort input that returns a run to IDLE.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start, n_in    start request (sampled in IDLE only) and index n
//   zero_flag      datapath ALU result == 0 for the current opcode
//   abort          (FIB_CTRL_ABORT_EN only) cancel the current run
//   wrt_addr, rd_addr1, rd_addr2, wrt_en, load_data, alu_opcode, count
//                  datapath control word
//   busy, done     status: busy outside IDLE; done pulses for one cycle
module fib_controller
   import fib_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] n_in,
   input  logic            zero_flag,
`ifdef FIB_CTRL_ABORT_EN
   input  logic            abort,
`endif
   output logic [1:0]      wrt_addr,
   output logic [1:0]      rd_addr1,
   output logic [1:0]      rd_addr2,
   output logic            wrt_en,
   output logic            load_data,
   output logic [2:0]      alu_opcode,
   output logic [SIZE-1:0] count,
   output logic            busy,
   output logic            done
);

   // Start protocol: start is a request level, looked at only while IDLE. The
   // edge that sees start high in IDLE accepts it and captures n_in; start at
   // any other time (including DONE) is dropped, never queued.

   state_e          state;
   state_e          state_nxt;
   logic [SIZE-1:0] n_q;
   ctrl_word_t      ctrl;
   logic            abort_hit;

`ifdef FIB_CTRL_ABORT_EN
   // DONE is excluded so a finished run always delivers its done pulse.
   assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         n_q   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start)
            n_q <= n_in;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort_hit) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = S_LD_N;
            S_LD_N:  state_nxt = S_LD_A;
            S_LD_A:  state_nxt = S_LD_B;
            S_LD_B:  state_nxt = S_TEST;
            S_TEST:  state_nxt = zero_flag ? S_DONE : S_ADD;
            S_ADD:   state_nxt = S_MOV1;
            S_MOV1:  state_nxt = S_MOV2;
            S_MOV2:  state_nxt = S_DEC;
            S_DEC:   state_nxt = S_TEST;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   fib_ctrl_decode #(.SIZE(SIZE)) u_decode (
      .state (state),
      .n_q   (n_q),
      .ctrl  (ctrl),
      .count (count)
   );

   assign wrt_addr   = ctrl.wrt_addr;
   assign rd_addr1   = ctrl.rd_addr1;
   assign rd_addr2   = ctrl.rd_addr2;
   // An abort suppresses the write of the state it lands in.
   assign wrt_en     = ctrl.wrt_en && !abort_hit;
   assign load_data  = ctrl.load_data;
   assign alu_opcode = ctrl.alu_opcode;
   assign busy       = ctrl.busy;
   assign done       = ctrl.done;

endmodule
